// File: rtl/evict_buffer_pkg.sv
// evict_buffer_pkg: shared widths and line types for the eviction staging buffer
package evict_buffer_pkg;
    localparam int ADDR_WIDTH      = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int BOW_DEFAULT     = 2;
    localparam int LINE_SIZE       = 1 << BOW_DEFAULT;
    localparam int LINE_ADDR_WIDTH = ADDR_WIDTH - BOW_DEFAULT - 2;
    typedef logic [LINE_ADDR_WIDTH-1:0] line_addr_t;
    typedef logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] line_data_t;
endpackage

// File: rtl/evict_buffer_match.sv
// evict_buffer_match: youngest-valid-match search over the circular entry array
module evict_buffer_match
    import evict_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = LINE_ADDR_WIDTH,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [DEPTH-1:0][AW-1:0] addr_i,
    input  logic [PW-1:0]            head_i,
    input  logic [AW-1:0]            probe_i,
    output logic                     hit_o,
    output logic [PW-1:0]            idx_o
);
    // Valid entries are exactly head..tail-1, so walking from head with last-match-wins picks the youngest
    always_comb begin
        hit_o = 1'b0;
        idx_o = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_i[head_i + PW'(k)] && addr_i[head_i + PW'(k)] == probe_i) begin
                hit_o = 1'b1;
                idx_o = head_i + PW'(k);
            end
        end
    end
endmodule

// File: rtl/evict_buffer_d.sv
// evict_buffer_d: FIFO of evicted L1 lines draining into the victim cache, with miss-path lookup.
// EVICT_BUFFER_COALESCE_EN: pushes matching a queued line overwrite it in place.
module evict_buffer_d
    import evict_buffer_pkg::*;
#(
    parameter int BLOCK_OFFSET_WIDTH = BOW_DEFAULT,
    parameter int DEPTH = 4,
    localparam int LS = 1 << BLOCK_OFFSET_WIDTH,
    localparam int LW = ADDR_WIDTH - BLOCK_OFFSET_WIDTH - 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push_valid,
    output logic                          o_push_ready,
    input  logic [LW-1:0]                 i_push_addr,
    input  logic [LS-1:0][DATA_WIDTH-1:0] i_push_data,
    output logic                          o_vc_we,
    output logic [LW-1:0]                 o_vc_waddr,
    output logic [LS-1:0][DATA_WIDTH-1:0] o_vc_wdata,
    input  logic                          i_vc_hold,
    input  logic [LW-1:0]                 i_lookup_addr,
    output logic                          o_lookup_hit,
    output logic [LS-1:0][DATA_WIDTH-1:0] o_lookup_data,
    output logic [CW-1:0]                 o_count,
    output logic                          o_empty,
    output logic                          o_full
);
    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [PW-1:0]                    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]                    count_q, count_d;
    logic [DEPTH-1:0][LW-1:0]         addr_q;
    logic [LS-1:0][DATA_WIDTH-1:0]    data_q [DEPTH];
    logic                             coalesce_hit, push_fire, alloc;
    logic                             l_hit;
    logic [PW-1:0]                    l_idx;

    assign o_count      = count_q;
    assign o_empty      = count_q == '0;
    assign o_full       = count_q == CW'(DEPTH);
    assign o_vc_we      = !o_empty && !i_vc_hold;
    assign o_vc_waddr   = addr_q[head_q];
    assign o_vc_wdata   = data_q[head_q];
    // A same-cycle drain never frees a slot for the push: no full bypass
    assign o_push_ready = !o_full || coalesce_hit;
    assign push_fire    = i_push_valid && o_push_ready;
    assign alloc        = push_fire && !coalesce_hit;

    evict_buffer_match #(.DEPTH(DEPTH), .AW(LW)) u_lookup (
        .valid_i (valid_q),
        .addr_i  (addr_q),
        .head_i  (head_q),
        .probe_i (i_lookup_addr),
        .hit_o   (l_hit),
        .idx_o   (l_idx)
    );
    assign o_lookup_hit  = l_hit;
    assign o_lookup_data = data_q[l_idx];

`ifdef EVICT_BUFFER_COALESCE_EN
    logic          c_hit;
    logic [PW-1:0] c_idx;
    evict_buffer_match #(.DEPTH(DEPTH), .AW(LW)) u_coalesce (
        .valid_i (valid_q),
        .addr_i  (addr_q),
        .head_i  (head_q),
        .probe_i (i_push_addr),
        .hit_o   (c_hit),
        .idx_o   (c_idx)
    );
    // The head leaving this cycle can't absorb the write; it must allocate fresh at the tail
    assign coalesce_hit = c_hit && !(o_vc_we && c_idx == head_q);
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[tail_q] <= i_push_addr;
            data_q[tail_q] <= i_push_data;
        end else if (push_fire) begin
            data_q[c_idx] <= i_push_data;
        end
    end
`else
    assign coalesce_hit = 1'b0;
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[tail_q] <= i_push_addr;
            data_q[tail_q] <= i_push_data;
        end
    end
`endif

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (o_vc_we) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (alloc) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        count_d = count_q + CW'(alloc) - CW'(o_vc_we);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: doc/evict_buffer_d.md
# evict_buffer_d

Eviction staging buffer directly upstream of the data-side victim cache. Captures whole lines evicted from the L1 data cache during refill, queues them in FIFO order, and drains one line per cycle into the victim cache write port (`i_we`/`i_waddr`/`i_wdata`) whenever that port is free. While queued, lines remain visible to the L1 miss path through a combinational lookup port, so no evicted line is ever invisible to a subsequent read.

## Interface
- `BLOCK_OFFSET_WIDTH`, default 2: log2 of words per line; `LINE_SIZE = 1 << BLOCK_OFFSET_WIDTH`.
- `DEPTH`, default 4: number of entries; must be a power of two, ≥ 2.
- `clk` input 1: the only clock.
- `rst` input 1: reset, asynchronous, active-high.
- `i_push_valid` input 1: the L1 presents an evicted line.
- `o_push_ready` output 1: the line is accepted at this edge if `i_push_valid` is also high.
- `i_push_addr` input `ADDR_WIDTH-BLOCK_OFFSET_WIDTH-2`: line address, bits `[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH+2]`.
- `i_push_data` input `DATA_WIDTH` × `LINE_SIZE`: line words.
- `o_vc_we` output 1: drives the victim cache `i_we`.
- `o_vc_waddr` output line-address width: drives the victim cache `i_waddr`.
- `o_vc_wdata` output `DATA_WIDTH` × `LINE_SIZE`: drives the victim cache `i_wdata`.
- `i_vc_hold` input 1: the victim cache port is reserved this cycle (a pipeline word write is in progress); no drain.
- `i_lookup_addr` input line-address width: miss-path probe address.
- `o_lookup_hit` output 1: a valid entry matches `i_lookup_addr`.
- `o_lookup_data` output `DATA_WIDTH` × `LINE_SIZE`: data of the youngest matching entry.
- `o_count` output `$clog2(DEPTH)+1`: number of occupied entries.
- `o_empty`, `o_full` output 1 each: occupancy flags.

## Operation
- **Storage**
  - Circular FIFO with head pointer, tail pointer and `count`.
  - Each entry holds a valid bit, a line address and `LINE_SIZE` words.
- **Drain**
  - `o_vc_we = !o_empty && !i_vc_hold`.
  - `o_vc_waddr` and `o_vc_wdata` always present the head entry's contents; their values are don't-care when empty.
  - At an edge where `o_vc_we` is high: clear the head valid bit, advance head modulo `DEPTH`, decrement `count`.
- **Push**
  - The line is accepted when `i_push_valid && o_push_ready`.
  - Allocation writes the tail entry, advances tail modulo `DEPTH` and increments `count`.
- **Ready rule**
  - `o_push_ready = !o_full || coalesce_hit`.
  - A drain in the same cycle does NOT free a slot for that cycle's push; there is no full-bypass.
  - `o_push_ready` is combinational on `i_push_addr`.
- **Simultaneous push and drain**
  - Both take effect; `count` is unchanged.
- **Lookup**
  - Compares `i_lookup_addr` against every valid entry.
  - On multiple matches, the entry youngest in FIFO order wins.
  - A line being pushed in the same cycle is not visible; the entry being drained this cycle is still visible until the edge.
- **Reset**
  - All valid bits cleared; head = tail = `count` = 0.
  - Outputs: `o_empty`=1, `o_full`=0, `o_count`=0, `o_vc_we`=0, `o_lookup_hit`=0.
  - `o_push_ready`=1 while reset is deasserted.
  - Reset mid-drain discards all queued lines; no partial write reaches the victim cache because `o_vc_we` falls immediately.
- **Wrap-around**
  - Pointers are `$clog2(DEPTH)` bits wide and wrap naturally.
  - Full/empty are derived from `count`, never from pointer equality.

## Timing
- Push to visible-on-lookup: 1 cycle (visible in the cycle after the accepting edge).
- Push to earliest `o_vc_we` when the buffer was empty and `i_vc_hold` is low: 1 cycle.
- Sustained throughput: 1 push and 1 drain per cycle.
- Hold: each cycle of `i_vc_hold` delays the drain by one cycle; head contents stay stable throughout.
- `o_vc_*` and `o_lookup_*` are combinational from registered state plus the `i_vc_hold`/`i_lookup_addr` inputs; they are not registered.

## Configuration
- Macro `EVICT_BUFFER_COALESCE_EN`.
- **Defined:** a push whose address matches a valid entry overwrites that entry's data in place instead of allocating.
  - Pointers and `count` are unchanged.
  - `coalesce_hit` is set, so the push is accepted even when full.
  - Exception: a match on the head entry while `o_vc_we` is high is not a coalesce; the push allocates a new entry at the tail, which requires `!o_full`.
- **Undefined:** `coalesce_hit` is 0; duplicate addresses allocate separate entries, and the youngest-match rule keeps lookups coherent.

## Structure
- Shared package `evict_buffer_pkg`:
  - `line_addr_t` (line-address width typedef).
  - `line_data_t` (`LINE_SIZE`-word array typedef).
  - `LINE_SIZE` constant.
- Sub-module `evict_buffer_match`:
  - Parameterised by `DEPTH`.
  - Takes per-entry valid/address vectors, head pointer and probe address.
  - Returns hit plus youngest-match index by age-ordered priority from tail-1 back to head.
  - Instantiated twice: once for lookup, once for coalesce.

## Test plan
- **Reset mid-drain:** reset → push A=0x100, B=0x101 with `i_vc_hold`=1; assert `rst` → next cycle `o_count`=0, `o_empty`=1, `o_vc_we`=0.
- **FIFO order:** push 0x10, 0x11, 0x12, 0x13 back-to-back with hold=1 → `o_full`=1, `o_push_ready`=0 for new address 0x14. Release hold → `o_vc_waddr` sequence 0x10, 0x11, 0x12, 0x13 on consecutive cycles with `o_vc_we`=1, then `o_empty`=1.
- **Hold:** one entry, `i_vc_hold` high for 3 cycles → `o_vc_we`=0 for exactly those 3 cycles, head data unchanged, drain on the 4th.
- **Full plus drain:** full buffer, push 0x20 while draining → `o_push_ready`=0 that cycle and `count` goes 4→3; the push is accepted the next cycle.
- **Lookup:** entries 0x30 (data 0xAAAA…) and 0x31 → probe 0x31 gives hit with matching data; probe 0x32 gives no hit. A push of 0x32 is invisible in its own accept cycle and hits the following cycle.
- **Coalesce with `EVICT_BUFFER_COALESCE_EN`:**
  - Full buffer containing 0x40 at a non-head slot, push 0x40 with new data → accepted, `count` stays 4, lookup returns the new data.
  - Without the macro → `o_push_ready`=0.
  - With the macro, push matching the head while draining → allocates at the tail.
